// File: rtl/multi_led_blinker.sv
// rtl/multi_led_blinker.sv - N-channel LED pattern generator with shared tick prescaler
// Each channel runs OFF/ON/BLINK/ONESHOT from a programmable half-period in ticks.
module multi_led_blinker #(
   parameter  int CHANNELS = 4,
   parameter  int CNT_W    = 16,
   parameter  int PRESCALE = 1000,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                system1000,
   input  logic                system1000_rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_chan,
   input  logic [1:0]          cfg_mode,
   input  logic [CNT_W-1:0]    cfg_half,
   output logic [CHANNELS-1:0] leds,
   output logic [CHANNELS-1:0] done,
   output logic                tick
);

   localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

   localparam logic [1:0] MODE_OFF     = 2'd0;
   localparam logic [1:0] MODE_BLINK   = 2'd2;
   localparam logic [1:0] MODE_ONESHOT = 2'd3;

   localparam logic [CHANNELS-1:0][CNT_W-1:0] HALF_RST = {CHANNELS{CNT_W'(1)}};

   logic                           cfg_ready_q;
   logic [PW-1:0]                  pre_q, pre_d;
   logic                           tick_q, tick_d;
   logic [CHANNELS-1:0][1:0]       mode_q, mode_d;
   logic [CHANNELS-1:0][CNT_W-1:0] half_q, half_d;
   logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [CHANNELS-1:0]            led_q, led_d;
   logic [CHANNELS-1:0]            done_q, done_d;
   logic                           wr_en;
   logic [CNT_W-1:0]               cfg_half_eff;

   assign wr_en        = cfg_valid && cfg_ready_q;
   // Storing half=0 as 1 keeps the half-1 compare from wrapping.
   assign cfg_half_eff = (cfg_half == '0) ? CNT_W'(1) : cfg_half;

   always_comb begin
      pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      tick_d = (pre_d == PRE_LAST);
   end

   always_comb begin
      mode_d = mode_q;
      half_d = half_q;
      cnt_d  = cnt_q;
      led_d  = led_q;
      done_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         // A write to this channel takes priority over a coincident tick.
         if (wr_en && (int'(cfg_chan) == i)) begin
            mode_d[i] = cfg_mode;
            half_d[i] = cfg_half_eff;
            cnt_d[i]  = '0;
            led_d[i]  = (cfg_mode != MODE_OFF);
         end else if (tick_q && ((mode_q[i] == MODE_BLINK) || (mode_q[i] == MODE_ONESHOT))) begin
            if (cnt_q[i] == (half_q[i] - 1'b1)) begin
               cnt_d[i] = '0;
               if (mode_q[i] == MODE_BLINK) begin
                  led_d[i] = ~led_q[i];
               end else begin
                  led_d[i]  = 1'b0;
                  mode_d[i] = MODE_OFF;
                  done_d[i] = 1'b1;
               end
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         cfg_ready_q <= 1'b0;
         pre_q       <= '0;
         tick_q      <= 1'b0;
         mode_q      <= '0;
         half_q      <= HALF_RST;
         cnt_q       <= '0;
         led_q       <= '0;
         done_q      <= '0;
      end else begin
         cfg_ready_q <= 1'b1;
         pre_q       <= pre_d;
         tick_q      <= tick_d;
         mode_q      <= mode_d;
         half_q      <= half_d;
         cnt_q       <= cnt_d;
         led_q       <= led_d;
         done_q      <= done_d;
      end
   end

   assign cfg_ready = cfg_ready_q;
   assign leds      = led_q;
   assign done      = done_q;
   assign tick      = tick_q;

endmodule

// File: tb/tb_multi_led_blinker.sv
// tb/tb_multi_led_blinker.sv - directed bench for multi_led_blinker
// Main instance: 4 channels, PRESCALE=4; second instance: 3 channels, PRESCALE=1.
module tb_multi_led_blinker;

   localparam logic [1:0] M_OFF     = 2'd0;
   localparam logic [1:0] M_ON      = 2'd1;
   localparam logic [1:0] M_BLINK   = 2'd2;
   localparam logic [1:0] M_ONESHOT = 2'd3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_chan;
   logic [1:0]  cfg_mode;
   logic [15:0] cfg_half;
   logic [3:0]  leds;
   logic [3:0]  done;
   logic        tick;

   logic        b_valid;
   logic        b_ready;
   logic [1:0]  b_chan;
   logic [1:0]  b_mode;
   logic [7:0]  b_half;
   logic [2:0]  b_leds;
   logic [2:0]  b_done;
   logic        b_tick;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   multi_led_blinker #(.CHANNELS(4), .CNT_W(16), .PRESCALE(4)) u_dut (
      .system1000     (clk),
      .system1000_rst (rst),
      .cfg_valid      (cfg_valid),
      .cfg_ready      (cfg_ready),
      .cfg_chan       (cfg_chan),
      .cfg_mode       (cfg_mode),
      .cfg_half       (cfg_half),
      .leds           (leds),
      .done           (done),
      .tick           (tick)
   );

   multi_led_blinker #(.CHANNELS(3), .CNT_W(8), .PRESCALE(1)) u_dut3 (
      .system1000     (clk),
      .system1000_rst (rst),
      .cfg_valid      (b_valid),
      .cfg_ready      (b_ready),
      .cfg_chan       (b_chan),
      .cfg_mode       (b_mode),
      .cfg_half       (b_half),
      .leds           (b_leds),
      .done           (b_done),
      .tick           (b_tick)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic go_to(input int t);
      while (cyc_n < t) begin
         @(negedge clk);
         cyc_n++;
      end
   endtask

   task automatic wr(input int t, input logic [1:0] ch, input logic [1:0] md, input logic [15:0] hf);
      go_to(t);
      cfg_valid = 1'b1;
      cfg_chan  = ch;
      cfg_mode  = md;
      cfg_half  = hf;
      go_to(t + 1);
      cfg_valid = 1'b0;
   endtask

   task automatic b_wr(input int t, input logic [1:0] ch, input logic [1:0] md, input logic [7:0] hf);
      go_to(t);
      b_valid = 1'b1;
      b_chan  = ch;
      b_mode  = md;
      b_half  = hf;
      go_to(t + 1);
      b_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      cfg_valid = 1'b0;
      cfg_chan  = '0;
      cfg_mode  = M_OFF;
      cfg_half  = '0;
      b_valid   = 1'b0;
      b_chan    = '0;
      b_mode    = M_OFF;
      b_half    = '0;

      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", cfg_ready, 0);
      chk("rst_leds", leds, 0);
      chk("rst_done", done, 0);
      chk("rst_tick", tick, 0);
      chk("rst_b_tick", b_tick, 0);

      // cycle 0: first cycle after the last reset edge
      @(negedge clk);
      cyc_n = 0;
      chk("ready_first", cfg_ready, 0);
      chk("b_ready_first", b_ready, 0);
      rst = 1'b0;

      go_to(1);
      chk("ready_on", cfg_ready, 1);
      chk("tick_c1", tick, 0);
      chk("b_tick_c1", b_tick, 1);
      chk("leds_c1", leds, 0);
      go_to(2);
      chk("tick_c2", tick, 0);
      chk("b_tick_c2", b_tick, 1);

      // PRESCALE=1 instance: oneshot half=2, then out-of-range channel write
      b_wr(2, 2'd1, M_ONESHOT, 8'd2);
      chk("tick_c3", tick, 1);
      chk("b_os_start", b_leds, 3'b010);
      chk("b_os_nodone", b_done, 0);
      go_to(4);
      chk("tick_c4", tick, 0);
      chk("b_os_mid", b_leds, 3'b010);
      go_to(5);
      chk("b_os_end_leds", b_leds, 3'b000);
      chk("b_os_end_done", b_done, 3'b010);
      go_to(6);
      chk("b_done_clear", b_done, 3'b000);
      b_wr(6, 2'd3, M_ON, 8'd1);
      chk("b_oor_leds", b_leds, 3'b000);
      chk("b_oor_done", b_done, 3'b000);
      chk("tick_c7", tick, 1);
      go_to(8);
      chk("b_oor_leds2", b_leds, 3'b000);

      // ch0 BLINK half=3: toggles on 3rd, 6th, 9th tick (ticks at 4k+3)
      wr(8, 2'd0, M_BLINK, 16'd3);
      chk("blink_start", leds, 4'b0001);
      go_to(19);
      chk("blink_pre_t3", leds, 4'b0001);
      go_to(20);
      chk("blink_t3", leds, 4'b0000);
      go_to(32);
      chk("blink_t6", leds[0], 1);
      go_to(44);
      chk("blink_t9", leds, 4'b0000);

      // ch2 ONESHOT half=2
      wr(45, 2'd2, M_ONESHOT, 16'd2);
      chk("os_start", leds[2], 1);
      chk("os_start_done", done, 0);
      go_to(51);
      chk("os_pre_leds", leds[2], 1);
      chk("os_pre_done", done, 0);
      go_to(52);
      chk("os_end_leds", leds[2], 0);
      chk("os_end_done", done, 4'b0100);
      go_to(53);
      chk("os_done_pulse", done, 0);
      go_to(60);
      chk("os_stays_off", leds[2], 0);

      // ch1 BLINK half=0 toggles every tick, then ON
      wr(61, 2'd1, M_BLINK, 16'd0);
      chk("h0_start", leds[1], 1);
      go_to(63);
      chk("h0_c63", leds[1], 1);
      go_to(64);
      chk("h0_c64", leds[1], 0);
      go_to(67);
      chk("h0_c67", leds[1], 0);
      go_to(68);
      chk("h0_c68", leds[1], 1);
      wr(69, 2'd1, M_ON, 16'd5);
      chk("on_c70", leds[1], 1);
      go_to(76);
      chk("on_c76", leds[1], 1);

      // ch3 ONESHOT half=5 written in a tick cycle; ch0 still takes that tick
      go_to(79);
      chk("tick_c79", tick, 1);
      chk("ch0_c79", leds[0], 0);
      wr(79, 2'd3, M_ONESHOT, 16'd5);
      chk("wt_start", leds[3], 1);
      chk("wt_ch0_toggle", leds[0], 1);
      go_to(96);
      chk("wt_c96_leds", leds[3], 1);
      chk("wt_c96_done", done, 0);
      go_to(99);
      chk("wt_c99_leds", leds[3], 1);
      go_to(100);
      chk("wt_end_leds", leds, 4'b0010);
      chk("wt_end_done", done, 4'b1000);
      go_to(101);
      chk("wt_done_clear", done, 0);

      // abort oneshot by rewriting as BLINK half=4
      wr(102, 2'd3, M_ONESHOT, 16'd3);
      chk("ab_start", leds[3], 1);
      wr(108, 2'd3, M_BLINK, 16'd4);
      chk("ab_blink_start", leds[3], 1);
      for (int t = 110; t <= 122; t++) begin
         go_to(t);
         chk("ab_no_done", done, 0);
      end
      go_to(123);
      chk("ab_c123", leds[3], 1);
      go_to(124);
      chk("ab_c124", leds[3], 0);
      chk("ab_c124_done", done, 0);

      // reset mid-pattern
      wr(125, 2'd2, M_ONESHOT, 16'd4);
      chk("mr_os_start", leds[2], 1);
      go_to(133);
      chk("mr_pre_leds", leds, 4'b0111);
      rst = 1'b1;
      go_to(134);
      chk("mr_leds", leds, 0);
      chk("mr_done", done, 0);
      chk("mr_ready", cfg_ready, 0);
      chk("mr_tick", tick, 0);
      rst = 1'b0;
      go_to(135);
      chk("mr_ready_on", cfg_ready, 1);
      go_to(136);
      chk("mr_tick_c136", tick, 0);
      go_to(137);
      chk("mr_tick_c137", tick, 1);
      go_to(141);
      chk("mr_tick_c141", tick, 1);
      go_to(154);
      chk("mr_stay_leds", leds, 0);
      chk("mr_stay_done", done, 0);
      wr(155, 2'd0, M_ON, 16'd0);
      chk("mr_rewrite", leds, 4'b0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
